// File: rtl/farm_car_detector_if.sv
// Farm-road detector bus: raw sensor and farm-green in, conditioned request and status out.
// Latency: none (wires only).
// Backpressure: none; every signal is a level, sampled each clock.
//
// Signals:
//   loop    - raw asynchronous loop-sensor level (1 = metal over loop)
//   fg      - farm-green indication from the light controller
//   car     - vehicle request to the light controller
//   present - debounced sensor level
//   waiting - number of vehicles queued on the farm road
//   fault   - sensor stuck-high flag
interface farm_car_detector_if #(
  parameter int CNT_W = 4
);
  logic             loop;
  logic             fg;
  logic             car;
  logic             present;
  logic [CNT_W-1:0] waiting;
  logic             fault;

  // master: the sensor / controller side of the link
  modport master (
    output loop, fg,
    input  car, present, waiting, fault
  );

  // slave: the detector itself
  modport slave (
    input  loop, fg,
    output car, present, waiting, fault
  );
endinterface

// File: rtl/farm_car_detector.sv
// Farm loop-sensor conditioner: sync + debounce, waiting-vehicle queue count, stuck-high detect.
// Latency: a clean Loop edge reaches Present DEBOUNCE+2 edges after it is first sampled; Car is
// combinational from registers. Backpressure: none, the controller samples Car every cycle.
//
// Ports:
//   clk_i   - system clock, all state on rising edge
//   rst_i   - asynchronous active-high reset, clears all state immediately
//   det_if  - slave side of farm_car_detector_if (loop/fg in; car/present/waiting/fault out)
module farm_car_detector #(
  parameter int DEBOUNCE    = 3,
  parameter int CNT_W       = 4,
  parameter int STUCK_LIMIT = 200,
  parameter int STUCK_W     = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  farm_car_detector_if.slave   det_if
);

  typedef enum logic [1:0] {
    ABSENT   = 2'd0,
    RISE_CHK = 2'd1,
    PRESENT  = 2'd2,
    FALL_CHK = 2'd3
  } state_t;

  localparam logic [3:0]         DEB_C   = 4'(DEBOUNCE);
  localparam logic [CNT_W-1:0]   WAIT_MAX = {CNT_W{1'b1}};
  localparam logic [STUCK_W-1:0] LIMIT_C = STUCK_W'(STUCK_LIMIT);

  // Two-flop synchroniser; only s2 is used past this point.
  logic s1_q, s2_q;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               present_q, present_d;
  logic [CNT_W-1:0]   waiting_q, waiting_d;
  logic [STUCK_W-1:0] stuck_q, stuck_d;
  logic               fault_q, fault_d;

  logic               arrival;
  logic               departure;
  logic               limit_hit;
  logic [STUCK_W-1:0] stuck_inc;

  // Debounce next state. The counter holds the length of the current run of samples that
  // disagree with the accepted level; the level flips on the edge that run reaches DEBOUNCE,
  // so DEBOUNCE=1 flips straight out of the stable state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ABSENT: begin
        if (s2_q) begin
          if (DEB_C <= 4'd1) begin
            state_d = PRESENT;
            cnt_d   = 4'd0;
          end else begin
            state_d = RISE_CHK;
            cnt_d   = 4'd1;
          end
        end
      end
      RISE_CHK: begin
        if (s2_q) begin
          if (cnt_q + 4'd1 >= DEB_C) begin
            state_d = PRESENT;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          state_d = ABSENT;
          cnt_d   = 4'd0;
        end
      end
      PRESENT: begin
        if (!s2_q) begin
          if (DEB_C <= 4'd1) begin
            state_d = ABSENT;
            cnt_d   = 4'd0;
          end else begin
            state_d = FALL_CHK;
            cnt_d   = 4'd1;
          end
        end
      end
      FALL_CHK: begin
        if (!s2_q) begin
          if (cnt_q + 4'd1 >= DEB_C) begin
            state_d = ABSENT;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          state_d = PRESENT;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = ABSENT;
        cnt_d   = 4'd0;
      end
    endcase
  end

  assign present_d = (state_d == PRESENT) || (state_d == FALL_CHK);
  assign arrival   = present_d & ~present_q;
  assign departure = ~present_d & present_q;

  // Stuck counter only runs while the vehicle is present and no fault is latched; the edge it
  // reaches the limit both raises Fault and flushes the queue so the highway is not starved.
  assign stuck_inc = stuck_q + 1'b1;
  assign limit_hit = present_q & ~fault_q & (stuck_inc == LIMIT_C);

  always_comb begin
    stuck_d = stuck_q;
    if (!present_q) begin
      stuck_d = '0;
    end else if (!fault_q) begin
      stuck_d = stuck_inc;
    end
  end

  // A departure while faulted only clears the fault; it is not a real vehicle leaving.
  always_comb begin
    waiting_d = waiting_q;
    if (limit_hit) begin
      waiting_d = '0;
    end else if (arrival && !det_if.fg) begin
      if (waiting_q != WAIT_MAX) waiting_d = waiting_q + 1'b1;
    end else if (departure && det_if.fg && !fault_q) begin
      if (waiting_q != '0) waiting_d = waiting_q - 1'b1;
    end
  end

  always_comb begin
    fault_d = fault_q;
    if (departure) begin
      fault_d = 1'b0;
    end else if (limit_hit) begin
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      state_q   <= ABSENT;
      cnt_q     <= 4'd0;
      present_q <= 1'b0;
      waiting_q <= '0;
      stuck_q   <= '0;
      fault_q   <= 1'b0;
    end else begin
      s1_q      <= det_if.loop;
      s2_q      <= s1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      present_q <= present_d;
      waiting_q <= waiting_d;
      stuck_q   <= stuck_d;
      fault_q   <= fault_d;
    end
  end

  // Car is built only from registered state so the controller sees no same-cycle path
  // from Loop or FG.
  assign det_if.car     = (present_q & ~fault_q) | (waiting_q != '0);
  assign det_if.present = present_q;
  assign det_if.waiting = waiting_q;
  assign det_if.fault   = fault_q;

endmodule

// File: doc/farm_car_detector.md
Name: farm_car_detector

Overview:
- Upstream conditioning stage for the highway/farm traffic-light controller: turns the raw farm-road loop-sensor input into the clean `Car` request that the controller consumes.
- Synchronises and debounces the sensor, counts waiting vehicles so a request survives sensor dropouts, and retires vehicles as they leave on farm green.
- Flags a stuck-high sensor so a faulty loop cannot starve the highway.

Parameters:
- DEBOUNCE, 3: consecutive synchronised samples at a new level needed to accept a level change (1..15).
- CNT_W, 4: width of the waiting-vehicle counter; saturates at 2^CNT_W-1.
- STUCK_LIMIT, 200: cycles of continuous debounced presence before Fault is raised (1..2^STUCK_W-1).
- STUCK_W, 8: width of the stuck-detect counter.

Ports:
- Clk  in  1  system clock, all state on rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- Loop  in  1  raw, asynchronous loop-sensor input (1 = metal over loop).
- FG  in  1  farm-green indication from the light controller (synchronous to Clk).
- Car  out  1  vehicle request to the light controller.
- Present  out  1  debounced sensor level.
- Waiting  out  CNT_W  number of vehicles queued on the farm road.
- Fault  out  1  sensor stuck-high flag.

Behaviour:
- Reset (asynchronous, active-high): sync flops=0, Present=0, debounce count=0, Waiting=0, stuck count=0, Fault=0, Car=0. Reset asserted mid-debounce or mid-count discards all progress.
- Synchroniser: two flops s1<=Loop, s2<=s1. Only s2 is used downstream.
- Debounce FSM, states ABSENT, RISE_CHK, PRESENT, FALL_CHK:
  - ABSENT: s2=1 -> RISE_CHK with cnt=1.
  - RISE_CHK: s2=1 -> cnt+1; when cnt reaches DEBOUNCE, go to PRESENT. s2=0 -> ABSENT, cnt=0.
  - PRESENT: s2=0 -> FALL_CHK with cnt=1.
  - FALL_CHK: s2=0 -> cnt+1; when cnt reaches DEBOUNCE, go to ABSENT. s2=1 -> PRESENT, cnt=0.
  - Present=1 in PRESENT and FALL_CHK.
- Latency: a clean Loop edge shows on Present DEBOUNCE+2 clock edges after the first edge that samples it. With DEBOUNCE=3, Present changes after the 5th edge.
- Arrival = Present 0->1 transition. Departure = Present 1->0 transition.
- Waiting counter:
  - Arrival with FG=0: increment, saturating at 2^CNT_W-1.
  - Arrival with FG=1: no change (vehicle passes through).
  - Departure with FG=1 and Waiting>0: decrement.
  - Departure with FG=0: no change (vehicle still queued, e.g. sensor dropout).
  - Waiting never wraps below 0 or above max.
  - Arrival and departure cannot coincide.
- Stuck detect:
  - Stuck counter increments each cycle Present=1 and Fault=0, and clears when Present=0.
  - When it reaches STUCK_LIMIT: Fault<=1 and Waiting<=0 on that edge.
  - Fault is sticky until a departure (Present falls) or Reset; it clears on the departure edge, and that departure does not decrement Waiting.
- Car = (Present & ~Fault) | (Waiting != 0). Combinational from registered state only; no dependence on Loop or FG within the cycle.
- FG has no effect on Car directly. The controller ends farm green itself when Car drops.

Test Plan:
- Reset check: Reset pulsed asynchronously between clock edges -> all outputs 0 immediately; Loop=1 during Reset produces nothing.
- Clean arrival: Loop 0->1 held, FG=0, DEBOUNCE=3 -> Present=1, Waiting=1, Car=1 after the 5th edge. Loop->0 -> Present=0 after 5 edges, Waiting stays 1, Car stays 1.
- Glitch rejection: Loop high for 2 cycles, then low -> Present, Waiting and Car remain 0. Likewise a 2-cycle low dip while Present=1 -> Present stays 1, no departure counted.
- Queue and retire: 3 separate arrivals with FG=0 -> Waiting=3. Set FG=1, produce 3 departures -> Waiting 2,1,0, and Car drops to 0 after the third departure.
- Saturation: 17 arrivals with FG=0, CNT_W=4 -> Waiting holds 15. A departure with Waiting=0 and FG=1 -> Waiting stays 0.
- Stuck sensor: Loop held high, FG=0, STUCK_LIMIT=200 -> Fault=1 and Waiting=0 exactly 200 cycles after Present rises, Car=0. Loop released -> Fault=0 at the departure edge, Waiting stays 0.
